mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage pipeline register and data-memory sequencer for the pipelined processor. It latches execute-stage results and control, runs a req/ack access to a multi-cycle data memory for loads and stores, stalls the upstream stages while an access is outstanding, and presents memory-stage control and data to the memory→writeback control register. The writeback side samples `regwrM` every clock, so this block must show a bubble (`regwrM`=0) whenever its instruction is not yet complete.

## Interface
- `DW`, 32, data and address width.
- `CLK` input 1: clock. All registers update on the rising edge.
- `RST_N` input 1: reset. Asynchronous, active-low.
- `validE` input 1: the execute-stage slot holds a real instruction.
- `regwrE` input 1: the instruction writes the register file.
- `memregE` input 2: writeback source select. The block passes it through and does not interpret it.
- `memrdE` input 1: the instruction is a load.
- `memwrE` input 1: the instruction is a store.
- `aluoutE` input DW: ALU result, also the memory address.
- `writedataE` input DW: store data.
- `writeregE` input 5: destination register.
- `flushM` input 1: load a bubble instead of the execute-stage instruction.
- `dmem_rdata` input DW: read data. Valid in the same cycle as `dmem_ack`.
- `dmem_ack` input 1: one-cycle completion pulse.
- `dmem_req` output 1: access request.
- `dmem_we` output 1: 1 = write, 0 = read.
- `dmem_addr` output DW: access address.
- `dmem_wdata` output DW: write data.
- `stallM` output 1: hold the fetch, decode and execute stages.
- `regwrM` output 1: to the writeback control register.
- `memregM` output 2: to the writeback control register.
- `aluoutM` output DW: ALU result of the memory-stage instruction.
- `readdataM` output DW: captured load data.
- `writeregM` output 5: destination register of the memory-stage instruction.

## Operation
- **M register.** It holds valid, regwr, memreg, memrd, memwr, aluout, writedata and writereg.
  - When `stallM`=0, it loads the E-stage inputs on each edge.
  - If `flushM`=1 on that edge, only valid is cleared (bubble).
  - When `stallM`=1, it holds.
- **FSM states.** IDLE, WAIT, DONE.
- **Transitions.** Evaluated on every edge where the M register loads, which is from IDLE or DONE:
  - If the loaded instruction has valid & (memrd|memwr), the next state is WAIT.
  - Otherwise the next state is IDLE.
  - In WAIT: `dmem_ack`=1 → DONE, and `dmem_rdata` is captured into `readdataM`. No ack → stay in WAIT.
- **Outputs.**
  - `stallM` = (state==WAIT).
  - `dmem_req` = (state==WAIT).
  - `dmem_we` = memwr_q. `dmem_addr` = aluout_q. `dmem_wdata` = writedata_q. All are stable for the whole request.
  - `regwrM` = valid_q & regwr_q & (state!=WAIT).
  - `memregM`, `aluoutM`, `writeregM` are driven directly from the M register.
  - `readdataM` holds its last captured value until the next ack in WAIT.
- **Boundary conditions.**
  - `dmem_ack` outside WAIT is ignored.
  - `flushM` while in WAIT is ignored; the access always completes.
  - Back-to-back memory ops: DONE loads the next op and goes straight to WAIT. There are no idle cycles between them.
  - A store with regwr=1 still completes normally; regwr is passed through.
  - If memrd and memwr are both 1, the instruction is treated as a store (`dmem_we`=1).
  - Reset mid-access: `dmem_req` drops asynchronously, the FSM returns to IDLE and the access is abandoned. A late ack after reset is ignored.

## Timing
- **Reset values.**
  - State IDLE; valid_q 0.
  - `stallM`, `dmem_req`, `dmem_we`, `regwrM` 0.
  - `memregM` 00; `writeregM` 0.
  - `aluoutM`, `readdataM`, `dmem_addr`, `dmem_wdata` 0.
- **Non-memory instruction.** Occupies M for exactly 1 cycle, with `regwrM` valid in that cycle.
- **Memory instruction.** Occupies M for N+1 cycles, where N ≥ 1 is the number of WAIT cycles up to and including the ack cycle.
  - `regwrM` is 0 in every WAIT cycle.
  - In the DONE cycle, `regwrM` is valid and `readdataM` holds the load data.
- **Stall window.** `stallM` is high exactly during the WAIT cycles, and falls in the cycle after the ack.
- **Request timing.** `dmem_req` rises in the first cycle after the instruction is latched and falls in the cycle after the ack. It stays high for at least one cycle.

## Test plan
- **ALU op passthrough.** regwrE=1, memregE=00, aluoutE=0x0000_0010, writeregE=5, no memory op.
  - Next cycle: `regwrM`=1, `aluoutM`=0x10, `writeregM`=5, `stallM`=0, `dmem_req`=0.
- **Load with delayed ack.** memrdE=1, aluoutE=0x100, regwrE=1, memregE=01. Ack 3 cycles after the request with `dmem_rdata`=0xDEADBEEF.
  - `stallM` and `dmem_req` are high for 3 cycles with `dmem_addr`=0x100 and `dmem_we`=0.
  - `regwrM` is 0 during those cycles.
  - In DONE: `regwrM`=1, `readdataM`=0xDEADBEEF.
- **Store with same-cycle ack.** memwrE=1, aluoutE=0x20, writedataE=0x55.
  - `dmem_req`=1, `dmem_we`=1, `dmem_wdata`=0x55 for 1 cycle, then DONE.
  - `stallM` is high for exactly 1 cycle.
- **Back-to-back loads, and flush during WAIT.**
  - Two consecutive loads each with a 1-cycle ack: 4 cycles total, `dmem_req` low only in the DONE cycles.
  - `flushM` pulsed during WAIT: no effect on the access.
- **Reset mid-WAIT.** Assert `RST_N`=0 with no clock edge.
  - `dmem_req` and `stallM` fall immediately; all outputs return to reset values.
  - A subsequent `dmem_ack` is ignored.
- **Stray ack in IDLE.** Pulse `dmem_ack` with `dmem_rdata`=0x1234 while in IDLE.
  - `readdataM` is unchanged.
  - The state stays IDLE.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage pipeline register plus req/ack sequencer for a multi-cycle data memory.
// While an access is outstanding the upstream stages are stalled and regwrM shows a bubble.
module mem_stage_ctrl #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          validE,
  input  logic          regwrE,
  input  logic [1:0]    memregE,
  input  logic          memrdE,
  input  logic          memwrE,
  input  logic [DW-1:0] aluoutE,
  input  logic [DW-1:0] writedataE,
  input  logic [4:0]    writeregE,
  input  logic          flushM,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          stallM,
  output logic          regwrM,
  output logic [1:0]    memregM,
  output logic [DW-1:0] aluoutM,
  output logic [DW-1:0] readdataM,
  output logic [4:0]    writeregM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_valid;
  logic          r_regwr;
  logic [1:0]    r_memreg;
  logic          r_memwr;
  logic [DW-1:0] r_aluout;
  logic [DW-1:0] r_writedata;
  logic [DW-1:0] r_readdata;
  logic [4:0]    r_writereg;

  logic w_valid_in;
  logic w_mem_op;
  logic w_waiting;

  // A flushed slot is a bubble, so it must never start an access.
  assign w_valid_in = validE & ~flushM;
  assign w_mem_op   = w_valid_in & (memrdE | memwrE);
  assign w_waiting  = (r_state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_regwr     <= 1'b0;
      r_memreg    <= 2'b00;
      r_memwr     <= 1'b0;
      r_aluout    <= '0;
      r_writedata <= '0;
      r_readdata  <= '0;
      r_writereg  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_valid     <= w_valid_in;
          r_regwr     <= regwrE;
          r_memreg    <= memregE;
          r_memwr     <= memwrE;
          r_aluout    <= aluoutE;
          r_writedata <= writedataE;
          r_writereg  <= writeregE;
          r_state     <= w_mem_op ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          // flushM is deliberately ignored here: an issued access always completes.
          if (dmem_ack) begin
            r_readdata <= dmem_rdata;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stallM     = w_waiting;
  assign dmem_req   = w_waiting;
  assign dmem_we    = r_memwr;
  assign dmem_addr  = r_aluout;
  assign dmem_wdata = r_writedata;

  assign regwrM     = r_valid & r_regwr & ~w_waiting;
  assign memregM    = r_memreg;
  assign aluoutM    = r_aluout;
  assign readdataM  = r_readdata;
  assign writeregM  = r_writereg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of the memory stage.
module tb_mem_stage_ctrl;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          validE, regwrE, memrdE, memwrE, flushM, dmem_ack;
  logic [1:0]    memregE;
  logic [DW-1:0] aluoutE, writedataE, dmem_rdata;
  logic [4:0]    writeregE;
  logic          dmem_req, dmem_we, stallM, regwrM;
  logic [DW-1:0] dmem_addr, dmem_wdata, aluoutM, readdataM;
  logic [1:0]    memregM;
  logic [4:0]    writeregM;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(.DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .validE(validE), .regwrE(regwrE), .memregE(memregE), .memrdE(memrdE), .memwrE(memwrE),
    .aluoutE(aluoutE), .writedataE(writedataE), .writeregE(writeregE), .flushM(flushM),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stallM(stallM), .regwrM(regwrM), .memregM(memregM), .aluoutM(aluoutM),
    .readdataM(readdataM), .writeregM(writeregM)
  );

  always #5 CLK = ~CLK;

  // Model: the instruction sitting in M, and whether its memory access is still outstanding.
  typedef struct {
    bit          valid;
    bit          regwr;
    bit [1:0]    memreg;
    bit          is_store;
    bit [DW-1:0] alu;
    bit [DW-1:0] wdata;
    bit [4:0]    wreg;
  } instr_t;

  instr_t      m_instr;
  bit          m_pending;
  bit [DW-1:0] m_loaded;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_instr   = '{default: 0};
      m_pending = 0;
      m_loaded  = 0;
    end else if (m_pending) begin
      if (dmem_ack) begin
        m_pending = 0;
        m_loaded  = dmem_rdata;
      end
    end else begin
      m_instr.valid    = validE && !flushM;
      m_instr.regwr    = regwrE;
      m_instr.memreg   = memregE;
      m_instr.is_store = memwrE;
      m_instr.alu      = aluoutE;
      m_instr.wdata    = writedataE;
      m_instr.wreg     = writeregE;
      m_pending        = m_instr.valid && (memrdE || memwrE);
    end
  end

  task automatic drive_e(input bit v, input bit rw, input bit [1:0] mr, input bit rd,
                         input bit wr, input bit [DW-1:0] alu, input bit [DW-1:0] wd,
                         input bit [4:0] wreg);
    validE = v; regwrE = rw; memregE = mr; memrdE = rd; memwrE = wr;
    aluoutE = alu; writedataE = wd; writeregE = wreg;
  endtask

  task automatic idle_cycles(input int n);
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    flushM = 0; dmem_ack = 0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    flushM = 0; dmem_ack = 0; dmem_rdata = '0;
    repeat (2) @(negedge CLK);
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stallM); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
    checks++; if (regwrM !== 1'b0) begin errors++; $display("FAIL reset_regwr: got %b expected 0", regwrM); end
    checks++; if ({memregM, writeregM} !== 7'd0) begin errors++; $display("FAIL reset_memreg_writereg: got %h expected 0", {memregM, writeregM}); end
    checks++; if ({aluoutM, readdataM, dmem_addr, dmem_wdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0", aluoutM, readdataM, dmem_addr, dmem_wdata);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_alu_passthrough;
    idle_cycles(1);
    drive_e(1, 1, 2'b00, 0, 0, 32'h0000_0010, 32'h0, 5'd5);
    @(negedge CLK);
    checks++; if (regwrM !== 1'b1) begin errors++; $display("FAIL alu_regwr: got %b expected 1", regwrM); end
    checks++; if (aluoutM !== 32'h10) begin errors++; $display("FAIL alu_aluout: got %h expected 10", aluoutM); end
    checks++; if (writeregM !== 5'd5) begin errors++; $display("FAIL alu_writereg: got %0d expected 5", writeregM); end
    checks++; if ({stallM, dmem_req} !== 2'b00) begin errors++; $display("FAIL alu_stall_req: got %b expected 00", {stallM, dmem_req}); end
    idle_cycles(1);
    checks++; if (regwrM !== 1'b0) begin errors++; $display("FAIL alu_one_cycle: got %b expected 0", regwrM); end
  endtask

  task automatic test_load_delayed;
    idle_cycles(1);
    drive_e(1, 1, 2'b01, 1, 0, 32'h100, 32'h0, 5'd7);
    @(negedge CLK);
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    for (int c = 1; c <= 3; c++) begin
      checks++; if ({stallM, dmem_req, dmem_we, regwrM} !== 4'b1100) begin
        errors++; $display("FAIL load_wait_c%0d: stall/req/we/regwr got %b expected 1100", c, {stallM, dmem_req, dmem_we, regwrM});
      end
      checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL load_addr_c%0d: got %h expected 100", c, dmem_addr); end
      dmem_ack = (c == 3); dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      @(negedge CLK);
    end
    dmem_ack = 0;
    checks++; if ({stallM, dmem_req, regwrM} !== 3'b001) begin errors++; $display("FAIL load_done_ctl: got %b expected 001", {stallM, dmem_req, regwrM}); end
    checks++; if (readdataM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_done_data: got %h expected deadbeef", readdataM); end
    checks++; if ({memregM, writeregM} !== {2'b01, 5'd7}) begin errors++; $display("FAIL load_done_dst: got %h expected %h", {memregM, writeregM}, {2'b01, 5'd7}); end
  endtask

  task automatic test_store_same_cycle;
    idle_cycles(1);
    drive_e(1, 0, 2'b00, 0, 1, 32'h20, 32'h55, 5'd0);
    @(negedge CLK);
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    checks++; if ({dmem_req, dmem_we, stallM} !== 3'b111) begin errors++; $display("FAIL store_req_we: got %b expected 111", {dmem_req, dmem_we, stallM}); end
    checks++; if (dmem_wdata !== 32'h55) begin errors++; $display("FAIL store_wdata: got %h expected 55", dmem_wdata); end
    dmem_ack = 1; dmem_rdata = 32'h0;
    @(negedge CLK);
    dmem_ack = 0;
    checks++; if ({stallM, dmem_req, regwrM} !== 3'b000) begin errors++; $display("FAIL store_done: got %b expected 000", {stallM, dmem_req, regwrM}); end
    // Both read and write set, with regwr: handled as a store that still writes back.
    drive_e(1, 1, 2'b10, 1, 1, 32'h44, 32'h66, 5'd9);
    @(negedge CLK);
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    checks++; if ({dmem_req, dmem_we, regwrM} !== 3'b110) begin errors++; $display("FAIL rdwr_is_store: got %b expected 110", {dmem_req, dmem_we, regwrM}); end
    dmem_ack = 1;
    @(negedge CLK);
    dmem_ack = 0;
    checks++; if ({stallM, regwrM, writeregM} !== {1'b0, 1'b1, 5'd9}) begin errors++; $display("FAIL store_regwr_pass: got %h expected %h", {stallM, regwrM, writeregM}, {1'b0, 1'b1, 5'd9}); end
  endtask

  task automatic test_back_to_back;
    idle_cycles(1);
    drive_e(1, 1, 2'b01, 1, 0, 32'h200, 32'h0, 5'd3);
    @(negedge CLK);
    checks++; if ({dmem_req, dmem_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL b2b_a_req: got %h expected 1_00000200", {dmem_req, dmem_addr}); end
    drive_e(1, 1, 2'b01, 1, 0, 32'h300, 32'h0, 5'd4);
    dmem_ack = 1; dmem_rdata = 32'hAAAA_0001;
    @(negedge CLK);
    dmem_ack = 0;
    checks++; if ({dmem_req, regwrM, readdataM} !== {1'b0, 1'b1, 32'hAAAA_0001}) begin
      errors++; $display("FAIL b2b_a_done: req/regwr/data got %b %b %h expected 0 1 aaaa0001", dmem_req, regwrM, readdataM);
    end
    @(negedge CLK);
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    checks++; if ({dmem_req, dmem_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL b2b_b_req: got %h expected 1_00000300", {dmem_req, dmem_addr}); end
    flushM = 1; dmem_ack = 1; dmem_rdata = 32'hBBBB_0002;
    @(negedge CLK);
    flushM = 0; dmem_ack = 0;
    checks++; if ({dmem_req, regwrM, writeregM, readdataM} !== {1'b0, 1'b1, 5'd4, 32'hBBBB_0002}) begin
      errors++; $display("FAIL b2b_b_done_flush: req/regwr/wreg/data got %b %b %0d %h expected 0 1 4 bbbb0002", dmem_req, regwrM, writeregM, readdataM);
    end
  endtask

  task automatic test_stray_ack;
    idle_cycles(2);
    dmem_ack = 1; dmem_rdata = 32'h1234;
    @(negedge CLK);
    dmem_ack = 0;
    checks++; if (readdataM !== 32'hBBBB_0002) begin errors++; $display("FAIL stray_ack_data: got %h expected bbbb0002", readdataM); end
    checks++; if ({stallM, dmem_req} !== 2'b00) begin errors++; $display("FAIL stray_ack_state: got %b expected 00", {stallM, dmem_req}); end
  endtask

  task automatic test_reset_mid_wait;
    idle_cycles(1);
    drive_e(1, 1, 2'b01, 1, 0, 32'h400, 32'h0, 5'd6);
    @(negedge CLK);
    drive_e(0, 0, 2'b00, 0, 0, '0, '0, '0);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b expected 1", dmem_req); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if ({dmem_req, stallM, regwrM, dmem_we} !== 4'b0000) begin errors++; $display("FAIL rst_mid_ctl: got %b expected 0000", {dmem_req, stallM, regwrM, dmem_we}); end
    checks++; if ({dmem_addr, aluoutM, readdataM, writeregM, memregM} !== '0) begin
      errors++; $display("FAIL rst_mid_data: addr/alu/rd got %h %h %h expected 0", dmem_addr, aluoutM, readdataM);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    dmem_ack = 0;
    checks++; if ({stallM, dmem_req, readdataM} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL rst_late_ack: stall/req/data got %b %b %h expected 0 0 0", stallM, dmem_req, readdataM);
    end
  endtask

  task automatic test_random;
    idle_cycles(1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if ({stallM, dmem_req} !== {m_pending, m_pending}) begin
        errors++; $display("FAIL rand_stall_req@%0d: got %b expected %b", cyc, {stallM, dmem_req}, {m_pending, m_pending});
      end
      checks++; if (regwrM !== (m_instr.valid && m_instr.regwr && !m_pending)) begin
        errors++; $display("FAIL rand_regwr@%0d: got %b expected %b", cyc, regwrM, m_instr.valid && m_instr.regwr && !m_pending);
      end
      checks++; if ({dmem_we, dmem_addr, dmem_wdata} !== {m_instr.is_store, m_instr.alu, m_instr.wdata}) begin
        errors++; $display("FAIL rand_dmem@%0d: we/addr/wdata got %b %h %h expected %b %h %h", cyc, dmem_we, dmem_addr, dmem_wdata, m_instr.is_store, m_instr.alu, m_instr.wdata);
      end
      checks++; if ({memregM, aluoutM, writeregM} !== {m_instr.memreg, m_instr.alu, m_instr.wreg}) begin
        errors++; $display("FAIL rand_mreg@%0d: got %h expected %h", cyc, {memregM, aluoutM, writeregM}, {m_instr.memreg, m_instr.alu, m_instr.wreg});
      end
      checks++; if (readdataM !== m_loaded) begin
        errors++; $display("FAIL rand_readdata@%0d: got %h expected %h", cyc, readdataM, m_loaded);
      end
      drive_e($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom,
              5'($urandom_range(0, 31)));
      flushM     = ($urandom_range(0, 5) == 0);
      dmem_ack   = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      @(negedge CLK);
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset;
    test_alu_passthrough;
    test_load_delayed;
    test_store_same_cycle;
    test_back_to_back;
    test_stray_ack;
    test_reset_mid_wait;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
